brush_writer: RTL
=================

# brush_writer

Write-side engine for the 128×128, 3-bit-per-pixel frame buffer that the VGA read path scans.
- Accepts brush commands (centre coordinate, colour, radius) or clear commands over a valid/ready handshake.
- Expands each command into a sequence of single-pixel writes: a clipped square stamp, or a full-canvas erase sweep.
- Issues each write only in cycles where the frame buffer grants a write slot, so the read path's alternate-cycle read/write split is never violated.

## Interface
Parameters:
- CANVAS_BITS, 7: bits per axis; canvas is 2^CANVAS_BITS square; address width is 2*CANVAS_BITS.
- MAX_RADIUS, 3: largest accepted stamp radius; side length = 2r+1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command this cycle
- cmd_clear  in  1  1 = clear-canvas command; x/y/color/radius ignored
- cmd_x  in  10  stamp centre x, screen coordinate, unsigned
- cmd_y  in  10  stamp centre y, screen coordinate, unsigned
- cmd_color  in  3  colour code written by the stamp
- cmd_radius  in  2  stamp radius r, 0..MAX_RADIUS
- wr_slot  in  1  frame buffer accepts a write this cycle
- wr_en  out  1  write strobe
- wr_addr  out  14  {y[6:0], x[6:0]}
- wr_data  out  3  colour code to write
- busy  out  1  command in progress

## Operation
- FSM states: IDLE, STAMP, CLEAR.
- cmd_ready is 1 only in IDLE. A command is accepted on a clk edge with cmd_valid & cmd_ready.
- Accept with cmd_clear=1:
  - Go to CLEAR with a 14-bit sweep counter at 0.
  - Each wr_slot cycle writes the ERASE colour at address = counter, then increments the counter.
  - After address 16383 is written, return to IDLE.
- Accept with cmd_clear=0:
  - Latch colour and r; radius values above MAX_RADIUS saturate to MAX_RADIUS.
  - Compute origin x0 = cmd_x − r, y0 = cmd_y − r as 11-bit signed values.
  - Go to STAMP. The cursor walks row-major (x fastest) over the (2r+1)² positions, starting at (x0, y0).
- Pixel clipping: a cursor position is on-canvas iff 0 ≤ x ≤ 127 and 0 ≤ y ≤ 127, tested on the full signed width and never on truncated bits.
  - On-canvas pixel: waits for wr_slot. In that cycle wr_en=1, and the cursor advances at the edge.
  - Off-canvas pixel: consumes exactly one cycle with wr_en=0, regardless of wr_slot, and the cursor advances.
- The last pixel's advance returns the FSM to IDLE.
- wr_en = (state≠IDLE) & pixel on-canvas & wr_slot. wr_addr and wr_data are 0 whenever wr_en=0.
- busy = (state≠IDLE).
- cmd_valid is ignored while busy. No command queueing.
- Reset, including mid-command: state → IDLE, counters/cursor → 0; pixels already written stay written.

## Timing
- Reset values: cmd_ready=1 (the cycle after reset deasserts), busy=0, wr_en=0, wr_addr=0, wr_data=0.
- Accept at edge k → busy=1 and the first write is possible in cycle k+1.
- wr_en is combinational from the registered cursor and wr_slot. The write takes effect at the edge ending the slot cycle.
- Stamp with wr_slot held at 1: exactly (2r+1)² busy cycles. cmd_ready returns the cycle after the last pixel.
- Stamp with wr_slot alternating: each on-canvas pixel takes at most 2 cycles; off-canvas pixels take 1.
- Clear: 16384 slot cycles (16384 with wr_slot=1; 32768 with alternating slot).
- Back-to-back: a new command can be accepted on the edge where the FSM enters IDLE + 1 cycle. There is no same-cycle turnaround.

## Structure
- Shared package fb_pkg holds:
  - CANVAS_BITS and the address width.
  - Colour code constants, including ERASE = 3'b000.
  - The state enum.
  - The radius type.
- One natural sub-module, stamp_cursor. It holds the signed origin, row/column counters, the side-length compare, and outputs on_canvas, cur_addr and last.
- brush_writer holds the FSM, the clear sweep counter, the handshake and output gating.

## Test plan
- Single pixel: cmd (x=5, y=7, color=3'b001, r=0), wr_slot=1 → exactly one wr_en pulse with addr 901, data 3'b001; busy for 1 cycle.
- Corner clip: cmd (0,0, r=1), wr_slot=1 → 9 busy cycles; wr_en only for addrs 0, 1, 128, 129, in that order.
- Slot gating: cmd (64,64, r=1), wr_slot toggling from 0 → 9 writes, addrs 8127..8129, 8255..8257, 8383..8385; wr_en never high while wr_slot=0; 18 busy cycles.
- Clear: clear cmd, wr_slot=1 → 16384 consecutive writes, addrs 0..16383, data ERASE; cmd_ready high the cycle after.
- Reset mid-stamp: assert reset on the 3rd cycle of an r=2 stamp → no further wr_en; next cycle busy=0, cmd_ready=1.
- Off-canvas: cmd (200,200, r=0) and (300,10, r=3) → zero writes; busy for 1 and 49 cycles respectively; commands arriving while busy are not accepted.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write path: canvas geometry,
// colour codes, FSM state encoding and the stamp radius type.
package fb_pkg;

    // Canvas geometry: 2^FB_CANVAS_BITS pixels per axis, row-major {y, x} addressing.
    localparam int FB_CANVAS_BITS = 7;
    localparam int FB_ADDR_W      = 2 * FB_CANVAS_BITS;
    localparam int FB_MAX_RADIUS  = 3;

    typedef logic [2:0] color_t;
    typedef logic [1:0] radius_t;

    // Colour codes understood by the VGA read path.
    localparam color_t COLOR_ERASE = 3'b000;
    localparam color_t COLOR_BLUE  = 3'b001;
    localparam color_t COLOR_GREEN = 3'b010;
    localparam color_t COLOR_RED   = 3'b100;
    localparam color_t COLOR_WHITE = 3'b111;

    // FSM state encoding, kept as plain constants for compatibility with older blocks.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_STAMP = 2'd1;
    localparam state_t ST_CLEAR = 2'd2;

    // Clamp a requested radius to the largest stamp the engine supports.
    function automatic radius_t sat_radius(input radius_t r, input radius_t max_r);
        radius_t res;
        if (r > max_r) begin
            res = max_r;
        end else begin
            res = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/stamp_cursor.sv
// Walks a (2r+1)^2 square row-major from a signed origin and reports, for the
// current position, whether it lies on the canvas, its frame-buffer address,
// and whether it is the final position of the stamp.
module stamp_cursor #(
    parameter int CANVAS_BITS = fb_pkg::FB_CANVAS_BITS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [9:0]                 cmd_x,
    input  logic [9:0]                 cmd_y,
    input  logic [1:0]                 radius,
    input  logic                       advance,
    output logic                       on_canvas,
    output logic [2*CANVAS_BITS-1:0]   cur_addr,
    output logic                       last
);
    import fb_pkg::*;

    logic signed [10:0] x0_q, x0_d;
    logic signed [10:0] y0_q, y0_d;
    logic [2:0]         col_q, col_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         max_q, max_d;
    logic signed [11:0] cur_x_s;
    logic signed [11:0] cur_y_s;

    // Cursor position, one bit wider than the origin so the far edge of a
    // stamp centred near x=1023 cannot wrap back onto the canvas.
    always_comb begin
        cur_x_s   = $signed({x0_q[10], x0_q}) + $signed({9'b0, col_q});
        cur_y_s   = $signed({y0_q[10], y0_q}) + $signed({9'b0, row_q});
        on_canvas = (cur_x_s[11:CANVAS_BITS] == {(12-CANVAS_BITS){1'b0}}) &&
                    (cur_y_s[11:CANVAS_BITS] == {(12-CANVAS_BITS){1'b0}});
        cur_addr  = {cur_y_s[CANVAS_BITS-1:0], cur_x_s[CANVAS_BITS-1:0]};
        last      = (col_q == max_q) && (row_q == max_q);
    end

    // Load origin/side on a new stamp, otherwise step x fastest, then y.
    always_comb begin
        x0_d  = x0_q;
        y0_d  = y0_q;
        col_d = col_q;
        row_d = row_q;
        max_d = max_q;
        if (load) begin
            x0_d  = $signed({1'b0, cmd_x}) - $signed({9'b0, radius});
            y0_d  = $signed({1'b0, cmd_y}) - $signed({9'b0, radius});
            max_d = {radius, 1'b0};
            col_d = 3'd0;
            row_d = 3'd0;
        end else if (advance) begin
            if (col_q == max_q) begin
                col_d = 3'd0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Cursor registers; synchronous reset parks everything at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q  <= 11'sd0;
            y0_q  <= 11'sd0;
            col_q <= 3'd0;
            row_q <= 3'd0;
            max_q <= 3'd0;
        end else begin
            x0_q  <= x0_d;
            y0_q  <= y0_d;
            col_q <= col_d;
            row_q <= row_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/brush_writer.sv
// Frame-buffer write engine: accepts brush/clear commands and expands them
// into single-pixel writes issued only in cycles the frame buffer grants.
module brush_writer #(
    parameter int CANVAS_BITS = fb_pkg::FB_CANVAS_BITS,
    parameter int MAX_RADIUS  = fb_pkg::FB_MAX_RADIUS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_clear,
    input  logic [9:0]               cmd_x,
    input  logic [9:0]               cmd_y,
    input  logic [2:0]               cmd_color,
    input  logic [1:0]               cmd_radius,
    input  logic                     wr_slot,
    output logic                     wr_en,
    output logic [2*CANVAS_BITS-1:0] wr_addr,
    output logic [2:0]               wr_data,
    output logic                     busy
);
    import fb_pkg::*;

    localparam int      ADDR_W = 2 * CANVAS_BITS;
    localparam radius_t MAX_R  = radius_t'(MAX_RADIUS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    color_t              color_q, color_d;

    logic                accept_s;
    logic                load_s;
    logic                advance_s;
    logic                pix_on_s;
    logic                cur_on_s;
    logic                cur_last_s;
    logic [ADDR_W-1:0]   cur_addr_s;
    radius_t             radius_s;

    stamp_cursor #(
        .CANVAS_BITS (CANVAS_BITS)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .radius    (radius_s),
        .advance   (advance_s),
        .on_canvas (cur_on_s),
        .cur_addr  (cur_addr_s),
        .last      (cur_last_s)
    );

    // Handshake, cursor control and write-port gating.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        accept_s  = cmd_valid & cmd_ready;
        load_s    = accept_s & ~cmd_clear;
        radius_s  = sat_radius(cmd_radius, MAX_R);

        case (state_q)
            ST_STAMP: pix_on_s = cur_on_s;
            ST_CLEAR: pix_on_s = 1'b1;
            default:  pix_on_s = 1'b0;
        endcase

        // Off-canvas pixels never wait for a slot; on-canvas pixels need one.
        if (state_q == ST_STAMP) begin
            advance_s = cur_on_s ? wr_slot : 1'b1;
        end else begin
            advance_s = 1'b0;
        end

        // A reset cycle mid-command must not leak one more write.
        wr_en = pix_on_s & wr_slot & ~reset;
        if (wr_en) begin
            if (state_q == ST_STAMP) begin
                wr_addr = cur_addr_s;
                wr_data = color_q;
            end else begin
                wr_addr = sweep_q;
                wr_data = COLOR_ERASE;
            end
        end else begin
            wr_addr = {ADDR_W{1'b0}};
            wr_data = 3'b000;
        end
    end

    // FSM next state, clear sweep and latched colour.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        color_d = color_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cmd_clear) begin
                        state_d = ST_CLEAR;
                        sweep_d = {ADDR_W{1'b0}};
                    end else begin
                        state_d = ST_STAMP;
                        color_d = cmd_color;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STAMP: begin
                if (advance_s && cur_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STAMP;
                end
            end
            ST_CLEAR: begin
                if (wr_slot) begin
                    sweep_d = sweep_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (sweep_q == {ADDR_W{1'b1}}) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; synchronous reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sweep_q <= {ADDR_W{1'b0}};
            color_q <= COLOR_ERASE;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            color_q <= color_d;
        end
    end

endmodule
